// File: rtl/pixel_downloader.sv
// Pixel FIFO to Avalon-MM write DMA: gathers 6 or 8 FIFO words into a 256-bit beat, writes it, waits for the response.
// Latency: first pop one cycle after start, write N+1 cycles after start; holds the beat while waitrequest, stalls on an empty FIFO.
module pixel_downloader #(
  parameter int USEDW_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [32:0]        avl_mm_addr,
  output logic               avl_mm_write,
  output logic [255:0]       avl_mm_writedata,
  output logic [31:0]        avl_mm_byteenable,
  input  logic               avl_mm_waitrequest,
  input  logic               avl_mm_writeresponsevalid,
  input  logic [1:0]         avl_mm_response,
  output logic               pix_fifo_read,
  input  logic [31:0]        pix_fifo_data,
  input  logic               pix_fifo_empty,
  input  logic [USEDW_W-1:0] pix_fifo_usedw,
  input  logic               enable,
  input  logic               word_mode,
  input  logic [31:0]        base_address,
  input  logic [31:0]        total_size,
  input  logic               transform_data,
  output logic               write_error,
  output logic               active
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_WAIT_RESP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_wcnt;
  logic [255:0]   r_slots;
  logic           r_xform;
  logic           r_word_mode;
  logic           r_err;
  logic           r_enable_q;
  logic [31:0]    r_cur_addr;
  logic [31:0]    r_base;

  logic [3:0]     w_n_idle;
  logic [3:0]     w_n;
  logic           w_start;
  logic           w_pop;
  logic           w_last_pop;
  logic           w_resp_ok;
  logic           w_resp_err;
  logic           w_enable_rise;
  logic [31:0]    w_next_addr;
  logic [255:0]   w_xform_data;

  // Beat size for the decision in IDLE uses the live input; once collecting, the latched copy.
  assign w_n_idle      = transform_data ? 4'd6 : 4'd8;
  assign w_n           = r_xform ? 4'd6 : 4'd8;
  assign w_start       = enable && !r_err && (pix_fifo_usedw >= USEDW_W'(w_n_idle));
  assign w_pop         = (r_state == S_COLLECT) && !pix_fifo_empty && ({1'b0, r_wcnt} < w_n);
  assign w_last_pop    = w_pop && ({1'b0, r_wcnt} == (w_n - 4'd1));
  assign w_resp_ok     = (r_state == S_WAIT_RESP) && avl_mm_writeresponsevalid && (avl_mm_response == 2'b00);
  assign w_resp_err    = (r_state == S_WAIT_RESP) && avl_mm_writeresponsevalid && (avl_mm_response != 2'b00);
  assign w_enable_rise = enable && !r_enable_q;
  assign w_next_addr   = r_cur_addr + (r_word_mode ? 32'd1 : 32'd32);

  always_comb begin
    w_state_nxt   = r_state;
    avl_mm_write  = 1'b0;
    active        = 1'b0;
    pix_fifo_read = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        active        = 1'b1;
        pix_fifo_read = w_pop;
        if (w_last_pop) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        active       = 1'b1;
        avl_mm_write = 1'b1;
        if (!avl_mm_waitrequest) w_state_nxt = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        active = 1'b1;
        if (avl_mm_writeresponsevalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Packed 24-bit pixels land in bytes 0..2 of each output word; byte 3 stays zero.
  always_comb begin
    w_xform_data = '0;
    for (int i = 0; i < 8; i++) begin
      w_xform_data[32*i +: 24] = r_slots[24*i +: 24];
    end
  end

  assign avl_mm_addr       = {1'b0, r_cur_addr};
  assign avl_mm_writedata  = r_xform ? w_xform_data : r_slots;
  assign avl_mm_byteenable = {32{avl_mm_write}};
  assign write_error       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_slots     <= '0;
      r_xform     <= 1'b0;
      r_word_mode <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_start) begin
        r_xform     <= transform_data;
        r_word_mode <= word_mode;
      end
      if (w_pop) begin
        r_slots[32*r_wcnt +: 32] <= pix_fifo_data;
        r_wcnt                   <= w_last_pop ? 3'd0 : r_wcnt + 3'd1;
      end
    end
  end

  // A fresh enable edge re-anchors the ring buffer even if a response advances in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable_q <= 1'b0;
      r_base     <= '0;
      r_cur_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_enable_q <= enable;
      if (w_enable_rise) begin
        r_base     <= base_address;
        r_cur_addr <= base_address;
      end else if (w_resp_ok) begin
        r_cur_addr <= (w_next_addr == (r_base + total_size)) ? r_base : w_next_addr;
      end
      if (w_resp_err) begin
        r_err <= 1'b1;
      end else if (!enable) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_downloader.sv
// Directed bench for pixel_downloader: show-ahead FIFO model plus a scripted Avalon write slave.
module tb_pixel_downloader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [32:0]  avl_mm_addr;
  logic         avl_mm_write;
  logic [255:0] avl_mm_writedata;
  logic [31:0]  avl_mm_byteenable;
  logic         wreq;
  logic         resp_vld;
  logic [1:0]   resp;
  logic         pix_fifo_read;
  logic [31:0]  pix_fifo_data;
  logic         pix_fifo_empty;
  logic [9:0]   pix_fifo_usedw;
  logic         enable;
  logic         word_mode;
  logic [31:0]  base_address;
  logic [31:0]  total_size;
  logic         transform_data;
  logic         write_error;
  logic         active;

  logic [31:0]  mem [0:255];
  logic [7:0]   wr_ptr = 8'd0;
  logic [7:0]   rd_ptr = 8'd0;
  logic [7:0]   fifo_cnt;
  logic         force_empty;
  int           pop_cnt = 0;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] last_data;
  logic [255:0] exp_data;

  pixel_downloader #(.USEDW_W(10)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .avl_mm_addr               (avl_mm_addr),
    .avl_mm_write              (avl_mm_write),
    .avl_mm_writedata          (avl_mm_writedata),
    .avl_mm_byteenable         (avl_mm_byteenable),
    .avl_mm_waitrequest        (wreq),
    .avl_mm_writeresponsevalid (resp_vld),
    .avl_mm_response           (resp),
    .pix_fifo_read             (pix_fifo_read),
    .pix_fifo_data             (pix_fifo_data),
    .pix_fifo_empty            (pix_fifo_empty),
    .pix_fifo_usedw            (pix_fifo_usedw),
    .enable                    (enable),
    .word_mode                 (word_mode),
    .base_address              (base_address),
    .total_size                (total_size),
    .transform_data            (transform_data),
    .write_error               (write_error),
    .active                    (active)
  );

  always #5 clk = ~clk;

  assign fifo_cnt       = wr_ptr - rd_ptr;
  assign pix_fifo_usedw = {2'b00, fifo_cnt};
  assign pix_fifo_empty = force_empty || (fifo_cnt == 8'd0);
  assign pix_fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (pix_fifo_read) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_write(output int waited);
    int n = 0;
    while (avl_mm_write !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    waited = n;
  endtask

  // Waits for a write, checks it, accepts it at once and returns the given response one cycle later.
  task automatic do_beat(input string tag, input logic [32:0] exp_addr, input logic [1:0] code, output int waited);
    wait_write(waited);
    chk($sformatf("%s_write", tag), avl_mm_write, 1);
    chk($sformatf("%s_addr", tag), avl_mm_addr, exp_addr);
    chk($sformatf("%s_be", tag), avl_mm_byteenable, 32'hFFFFFFFF);
    last_data = avl_mm_writedata;
    @(negedge clk);
    resp_vld = 1'b1;
    resp     = code;
    @(negedge clk);
    resp_vld = 1'b0;
    resp     = 2'b00;
  endtask

  initial begin
    int st;
    int n;
    int cnt;
    rst_n = 1'b0; wreq = 1'b0; resp_vld = 1'b0; resp = 2'b00; force_empty = 1'b0;
    enable = 1'b0; word_mode = 1'b0; transform_data = 1'b0;
    base_address = 32'h0; total_size = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", avl_mm_addr, 0);
    chk("rst_write", avl_mm_write, 0);
    chk("rst_wdata", avl_mm_writedata, 0);
    chk("rst_be", avl_mm_byteenable, 0);
    chk("rst_read", pix_fifo_read, 0);
    chk("rst_err", write_error, 0);
    chk("rst_active", active, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Transform beat: bytes 0..23 packed three per word.
    base_address = 32'h1000; total_size = 32'h1000; transform_data = 1'b1;
    for (int k = 0; k < 6; k++) push(32'h03020100 + 32'h04040404 * k);
    st = pop_cnt;
    enable = 1'b1;
    do_beat("xform", 33'h1000, 2'b00, n);
    chk("xform_latency", n, 7);
    chk("xform_data", last_data, 256'h00171615_00141312_0011100F_000E0D0C_000B0A09_00080706_00050403_00020100);
    chk("xform_pops", pop_cnt - st, 6);

    // Pass-through beat, address advanced by 32.
    transform_data = 1'b0;
    for (int k = 0; k < 8; k++) push(32'hA0000000 + k);
    st = pop_cnt;
    do_beat("pass", 33'h1020, 2'b00, n);
    chk("pass_latency", n, 9);
    for (int k = 0; k < 8; k++) exp_data[32*k +: 32] = 32'hA0000000 + k;
    chk("pass_data", last_data, exp_data);
    chk("pass_pops", pop_cnt - st, 8);

    // Waitrequest for 3 cycles; an error strobe in the acceptance cycle must be ignored.
    wreq = 1'b1;
    for (int k = 0; k < 8; k++) push(32'hB0000000 + k);
    for (int k = 0; k < 8; k++) exp_data[32*k +: 32] = 32'hB0000000 + k;
    wait_write(n);
    for (int i = 0; i < 4; i++) begin
      chk("stall_write", avl_mm_write, 1);
      chk("stall_addr", avl_mm_addr, 33'h1040);
      chk("stall_data", avl_mm_writedata, exp_data);
      if (i == 3) begin
        wreq = 1'b0; resp_vld = 1'b1; resp = 2'b11;
      end
      @(negedge clk);
    end
    chk("stall_released", avl_mm_write, 0);
    resp = 2'b00;
    @(negedge clk);
    resp_vld = 1'b0;
    chk("stall_no_err", write_error, 0);

    // FIFO empty for 2 cycles after the third pop.
    for (int k = 0; k < 8; k++) push(32'hC0000000 + k);
    st = pop_cnt; n = 0;
    while (pop_cnt - st < 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    force_empty = 1'b1;
    #1;
    chk("empty_read0", pix_fifo_read, 0);
    @(negedge clk);
    chk("empty_read1", pix_fifo_read, 0);
    @(negedge clk);
    chk("empty_pops_held", pop_cnt - st, 3);
    force_empty = 1'b0;
    do_beat("empty", 33'h1060, 2'b00, n);
    for (int k = 0; k < 8; k++) exp_data[32*k +: 32] = 32'hC0000000 + k;
    chk("empty_data", last_data, exp_data);
    chk("empty_pops", pop_cnt - st, 8);

    // Wrap in byte mode then word mode.
    enable = 1'b0;
    @(negedge clk);
    total_size = 32'h40; enable = 1'b1;
    for (int k = 0; k < 24; k++) push(k);
    do_beat("wrapb0", 33'h1000, 2'b00, n);
    do_beat("wrapb1", 33'h1020, 2'b00, n);
    do_beat("wrapb2", 33'h1000, 2'b00, n);
    enable = 1'b0;
    @(negedge clk);
    word_mode = 1'b1; total_size = 32'h2; enable = 1'b1;
    for (int k = 0; k < 24; k++) push(k);
    do_beat("wrapw0", 33'h1000, 2'b00, n);
    do_beat("wrapw1", 33'h1001, 2'b00, n);
    do_beat("wrapw2", 33'h1000, 2'b00, n);

    // Error response blocks further beats until enable is cycled.
    enable = 1'b0;
    @(negedge clk);
    word_mode = 1'b0; base_address = 32'h2000; total_size = 32'h1000; enable = 1'b1;
    for (int k = 0; k < 28; k++) push(32'hE0000000 + k);
    do_beat("err", 33'h2000, 2'b10, n);
    chk("err_flag", write_error, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (avl_mm_write || active) cnt++;
      @(negedge clk);
    end
    chk("err_blocked", cnt, 0);
    chk("err_usedw", pix_fifo_usedw, 20);
    enable = 1'b0; base_address = 32'h3000;
    @(negedge clk);
    chk("err_cleared", write_error, 0);
    enable = 1'b1;
    do_beat("rec0", 33'h3000, 2'b00, n);
    do_beat("rec1", 33'h3020, 2'b00, n);

    // Enable dropped after 3 pops: beat completes, then idle.
    for (int k = 0; k < 4; k++) push(32'hD0000000 + k);
    st = pop_cnt; n = 0;
    while (pop_cnt - st < 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    do_beat("drop", 33'h3040, 2'b00, n);
    chk("drop_pops", pop_cnt - st, 8);
    chk("drop_idle", active, 0);
    for (int k = 0; k < 8; k++) push(32'hF0000000 + k);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (avl_mm_write || active) cnt++;
      @(negedge clk);
    end
    chk("drop_stays_idle", cnt, 0);

    // Reset asserted while WRITE is high.
    enable = 1'b1; wreq = 1'b1;
    wait_write(n);
    chk("rst_mid_write_seen", avl_mm_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", avl_mm_write, 0);
    chk("rst_mid_active", active, 0);
    chk("rst_mid_be", avl_mm_byteenable, 0);
    chk("rst_mid_addr", avl_mm_addr, 0);
    @(negedge clk);
    rst_n = 1'b1; wreq = 1'b0; enable = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_downloader.md
# pixel_downloader

Write-direction DMA: pops pixel words from the receive pixel FIFO, optionally expands packed 3-byte pixels to 4-byte memory format, and writes 256-bit beats to memory through an Avalon-MM write-only master. It is the mirror of the memory-to-FIFO pixel uploader. It stores incoming frames into a circular buffer at `base_address` spanning `total_size` address units.

## Interface
- `USEDW_W`, default 10: width of `pix_fifo_usedw`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `avl_mm_addr` out 33: write address, `{1'b0, cur_addr}`.
- `avl_mm_write` out 1: write request.
- `avl_mm_writedata` out 256: beat data.
- `avl_mm_byteenable` out 32: always all ones while `avl_mm_write` is high, else 0.
- `avl_mm_waitrequest` in 1: slave stall.
- `avl_mm_writeresponsevalid` in 1: write response strobe.
- `avl_mm_response` in 2: response code; nonzero is an error.
- `pix_fifo_read` out 1: pop strobe. The FIFO is show-ahead, so data is valid whenever `pix_fifo_empty` is low.
- `pix_fifo_data` in 32: FIFO head word.
- `pix_fifo_empty` in 1: FIFO empty.
- `pix_fifo_usedw` in USEDW_W: FIFO fill level.
- `enable` in 1: run.
- `word_mode` in 1: 1 selects word addressing (increment 1 per beat); 0 selects byte addressing (increment 32).
- `base_address` in 32: buffer start, latched on the `enable` rising edge.
- `total_size` in 32: buffer length in address units; must be a multiple of the per-beat increment.
- `transform_data` in 1: 1 expands 24-bit packed input into 32-bit words with zero byte 3; 0 passes words through.
- `write_error` out 1: sticky error flag.
- `active` out 1: high when the state is not IDLE.

## Operation
- **Beat size.** N = 6 input words when `transform_data` = 1, N = 8 when 0. `transform_data` and `word_mode` are sampled on leaving IDLE and held until the beat completes.
- **States.** IDLE, COLLECT, WRITE, WAIT_RESP.
- **IDLE → COLLECT** when all of these hold:
  - `enable` = 1;
  - `err_reg` = 0;
  - `pix_fifo_usedw` >= N.
- **COLLECT.**
  - `pix_fifo_read` = (state == COLLECT) && !`pix_fifo_empty` && (wcnt < N). It is combinational.
  - On each pop, `pix_fifo_data` is stored into assembly slot `wcnt` (bits [32·wcnt+:32]), and the 3-bit `wcnt` increments.
  - Empty FIFO: stall with no pop and no counter change.
  - After the pop with wcnt = N-1: go to WRITE and clear wcnt.
- **Beat mapping.**
  - Pass-through: writedata = the 256-bit slot vector.
  - Transform: the 192-bit slot vector is taken as bytes b0..b23.
  - Output byte i with i%4 != 3 takes the next b in ascending order.
  - Output byte i with i%4 == 3 is 0x00.
  - Example: output bytes 0,1,2 = b0,b1,b2; output byte 3 = 0; output byte 4 = b3.
- **WRITE.**
  - `avl_mm_write` = 1.
  - `avl_mm_addr`, `avl_mm_writedata` and `avl_mm_byteenable` are held stable while `avl_mm_waitrequest` = 1.
  - Accepted on the first cycle with `avl_mm_waitrequest` = 0; then go to WAIT_RESP.
- **WAIT_RESP.** Waits for `avl_mm_writeresponsevalid`.
  - `avl_mm_response` == 0: advance the address and go to IDLE.
  - Nonzero: set `err_reg`, do not advance the address, go to IDLE.
- **Address.**
  - Enable rising edge (`enable` & !`enable_q`): `base_reg` <= `base_address` and `cur_addr` <= `base_address`.
  - Advance: next = `cur_addr` + (`word_mode` ? 1 : 32), 32-bit unsigned.
  - Wrap: if next == `base_reg` + `total_size`, `cur_addr` <= `base_reg`.
  - An enable rising edge takes priority over an advance in the same cycle.
- **Errors.** `write_error` = `err_reg`. `err_reg` is cleared while `enable` = 0. A new error takes priority over the clear in the same cycle.
- **Enable dropped mid-beat.** A beat in COLLECT, WRITE or WAIT_RESP runs to completion, so popped words are never discarded. The FSM then stays in IDLE.
- **`pix_fifo_empty` during WRITE or WAIT_RESP:** ignored.

## Timing
- **Reset values.** All outputs are 0: `avl_mm_addr`, `avl_mm_write`, `avl_mm_writedata`, `avl_mm_byteenable`, `pix_fifo_read`, `write_error`, `active`. Internal: state = IDLE, `cur_addr` = 0, `base_reg` = 0, wcnt = 0, `err_reg` = 0, `enable_q` = 0.
- **Reset mid-operation** returns everything to the reset values immediately. No write is held.
- **Output registering.**
  - `avl_mm_write` and `active` are decoded from the registered state and are glitch-free.
  - `avl_mm_writedata` comes from the assembly register.
- **Latency.**
  - Condition true in IDLE at cycle t: first pop at t+1.
  - With a non-empty FIFO, N pops occur on consecutive cycles t+1..t+N.
  - `avl_mm_write` is high from t+N+1.
- **Throughput.** One beat per N+3 cycles minimum: N pops, 1 WRITE cycle with zero wait, a response at the earliest one cycle later, and 1 IDLE cycle.
- **Response timing.** `avl_mm_writeresponsevalid` arriving in the same cycle as acceptance is ignored. Only responses received in WAIT_RESP count.

## Test plan
- **Transform beat.** `transform_data`=1, base 0x1000, byte mode, FIFO words 0x03020100, 0x07060504, …, 0x17161514. Required: one write to addr 0x1000 with byte0..7 = 00 01 02 00 03 04 05 00 and bytes 28..31 = 15 16 17 00; byteenable 0xFFFFFFFF; exactly 6 `pix_fifo_read` pulses.
- **Pass-through.** `transform_data`=0, 8 words 0xA0000000+k. Required: writedata[32k+:32] = 0xA0000000+k; then the next write lands at addr 0x1020.
- **Wait and stall.** `avl_mm_waitrequest` held high for 3 cycles. Required: `avl_mm_write` high for 4 cycles with addr and data stable throughout. Separately, `pix_fifo_empty` pulsed for 2 cycles mid-COLLECT: no pops during those cycles and the data order is preserved.
- **Wrap.** base 0x1000, `total_size` 0x40, byte mode, 3 beats. Required: addresses 0x1000, 0x1020, 0x1000. Repeat in word mode with `total_size` 2: addresses 0x1000, 0x1001, 0x1000.
- **Error.** `avl_mm_response`=2'b10 on the first beat. Required:
  - `write_error`=1 the next cycle;
  - no further writes while `enable` stays high, even with `pix_fifo_usedw`=20;
  - after `enable` low then high: `write_error`=0 and the next write goes to `base_address`.
- **Enable drop and reset.**
  - `enable` dropped after 3 pops: the beat still completes with one write, then `active`=0.
  - `rst_n` asserted during WRITE: `avl_mm_write`=0 and `active`=0 immediately.
